// File: rtl/fir_pkg.sv
// Shared constants, state encoding and coefficient type for the FIR coefficient loader.
package fir_pkg;

  localparam int NTAPS   = 21;  // coefficient count, equal to the FIR tap count
  localparam int CW      = 16;  // coefficient width
  localparam int NVERIFY = 16;  // taps checked on readback (indices 0..NVERIFY-1)
  localparam int GAP_DEF = 3;   // default idle cycles around each shift strobe
  localparam int AW      = 5;   // table address width
  localparam int SW      = 4;   // readback tap-select width

  typedef logic [CW-1:0] coef_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coef_table.sv
// Host-written coefficient table: NTAPS x CW register file, one synchronous
// write port and one asynchronous read port. Contents are deliberately not reset.
module fir_coef_table
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  coef_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output coef_t         rd_data
);

  localparam logic [AW-1:0] DEPTH = AW'(NTAPS);

  coef_t mem [NTAPS];

  // Store host writes; addresses beyond the table are dropped silently.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so a write lands on the very next LOAD/VERIFY cycle.
  assign rd_data = (rd_addr < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/fir_coef_loader.sv
// FIR coefficient loader: shifts the coefficient table into the FIR tap chain
// (last tap first, GAP idle cycles before each strobe), then reads taps
// 0..NVERIFY-1 back through the FIR tap-select port and compares them.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int GAP = GAP_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          start,
  output logic [CW-1:0] coef_out,
  output logic          coef_shift,
  output logic [SW-1:0] sel,
  input  logic [CW-1:0] coef_rb,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [SW-1:0] err_idx
);

  localparam int            GW       = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_L    = GW'(GAP);
  localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
  localparam logic [SW-1:0] LAST_VI  = SW'(NVERIFY - 1);

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;       // table index being sent during LOAD
  logic [GW-1:0] gap_reg, gap_next;       // strobe fires when this reaches GAP
  logic [SW-1:0] sel_reg, sel_next;       // doubles as the VERIFY tap counter
  logic          phase_reg, phase_next;   // 0 = settle cycle, 1 = compare cycle
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;
  logic [SW-1:0] err_idx_reg, err_idx_next;
  logic          ret_reg, ret_next;       // first IDLE cycle after finishing

  logic [AW-1:0] rd_addr;
  coef_t         tab_data;

  // One read port serves both phases: LOAD walks idx downwards, VERIFY walks sel upwards.
  assign rd_addr = (state_reg == S_VERIFY) ? AW'(sel_reg) : idx_reg;

  fir_coef_table u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (tab_data)
  );

  // Present the pending coefficient for the whole gap so it is settled before its strobe.
  assign coef_out   = (state_reg == S_LOAD) ? tab_data : '0;
  assign coef_shift = (state_reg == S_LOAD) && (gap_reg == GAP_L);
  assign sel        = sel_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign err_idx    = err_idx_reg;

  // State and counter registers; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      gap_reg     <= '0;
      sel_reg     <= '0;
      phase_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      err_idx_reg <= '0;
      ret_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      gap_reg     <= gap_next;
      sel_reg     <= sel_next;
      phase_reg   <= phase_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
      err_idx_reg <= err_idx_next;
      ret_reg     <= ret_next;
    end
  end

  // Next-state logic: accept start, pace the shift strobes, then settle/compare each tap.
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    gap_next     = gap_reg;
    sel_next     = sel_reg;
    phase_next   = phase_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = error_reg;
    err_idx_next = err_idx_reg;
    ret_next     = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        // A start coinciding with the return to IDLE is dropped via ret_reg.
        if (start && !ret_reg) begin
          state_next   = S_LOAD;
          busy_next    = 1'b1;
          error_next   = 1'b0;
          err_idx_next = '0;
          idx_next     = LAST_IDX;
          gap_next     = '0;
        end
      end

      S_LOAD: begin
        if (gap_reg == GAP_L) begin
          gap_next = '0;
          if (idx_reg == '0) begin
            state_next = S_VERIFY;
            sel_next   = '0;
            phase_next = 1'b0;
          end else begin
            idx_next = idx_reg - AW'(1);
          end
        end else begin
          gap_next = gap_reg + GW'(1);
        end
      end

      S_VERIFY: begin
        if (!phase_reg) begin
          phase_next = 1'b1;
        end else begin
          phase_next = 1'b0;
          if (coef_rb != tab_data) begin
            error_next   = 1'b1;
            err_idx_next = sel_reg;
            busy_next    = 1'b0;
            ret_next     = 1'b1;
            state_next   = S_IDLE;
          end else if (sel_reg == LAST_VI) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            ret_next   = 1'b1;
            state_next = S_IDLE;
          end else begin
            sel_next = sel_reg + SW'(1);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: two instances (GAP=3 and GAP=0), each driving a
// behavioural 21-deep FIR shift chain with a readback mux that can be forced.
module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        start3 = 1'b0, start0 = 1'b0;

  logic [15:0] coef3, coef0, rb3, rb0;
  logic        shift3, shift0, busy3, busy0, done3, done0, error3, error0;
  logic [3:0]  sel3, sel0, eidx3, eidx0;

  logic [15:0] tap3 [21];
  logic [15:0] tap0 [21];

  bit          force_en = 1'b0;
  int          force_idx = 0;
  logic [15:0] force_val = '0;

  int which_r = 0;   // 0 -> GAP=3 instance, 1 -> GAP=0 instance
  int cyc = 0;
  int strb_n = 0;
  int done_cnt = 0;
  logic [15:0] strb_val [64];
  int          strb_cyc [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_coef_loader #(.GAP(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start3), .coef_out(coef3), .coef_shift(shift3), .sel(sel3), .coef_rb(rb3),
    .busy(busy3), .done(done3), .error(error3), .err_idx(eidx3)
  );

  fir_coef_loader #(.GAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start0), .coef_out(coef0), .coef_shift(shift0), .sel(sel0), .coef_rb(rb0),
    .busy(busy0), .done(done0), .error(error0), .err_idx(eidx0)
  );

  // FIR model: new coefficient enters tap[0], older ones move up the chain.
  always @(posedge clk) begin
    if (shift3) begin
      tap3[0] <= coef3;
      for (int k = 1; k < 21; k++) tap3[k] <= tap3[k-1];
    end
    if (shift0) begin
      tap0[0] <= coef0;
      for (int k = 1; k < 21; k++) tap0[k] <= tap0[k-1];
    end
  end

  assign rb3 = (force_en && force_idx == int'(sel3)) ? force_val : tap3[sel3];
  assign rb0 = (force_en && force_idx == int'(sel0)) ? force_val : tap0[sel0];

  logic        cur_shift, cur_done, cur_error, cur_busy;
  logic [15:0] cur_coef;
  logic [3:0]  cur_eidx;
  assign cur_shift = (which_r == 1) ? shift0 : shift3;
  assign cur_done  = (which_r == 1) ? done0  : done3;
  assign cur_error = (which_r == 1) ? error0 : error3;
  assign cur_busy  = (which_r == 1) ? busy0  : busy3;
  assign cur_coef  = (which_r == 1) ? coef0  : coef3;
  assign cur_eidx  = (which_r == 1) ? eidx0  : eidx3;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (cur_shift) begin
      if (strb_n < 64) begin
        strb_val[strb_n] = cur_coef;
        strb_cyc[strb_n] = cyc;
      end
      strb_n++;
    end
    if (cur_done) done_cnt++;
  end

  function automatic logic [15:0] pat_val(input int pat, input int k);
    case (pat)
      0:       return 16'(k * 257);
      1:       return 16'hFFFF;
      default: return 16'hA5A5 ^ 16'(k << 8);
    endcase
  endfunction

  function automatic logic [15:0] model_tap(input int w, input int k);
    return (w == 1) ? tap0[k] : tap3[k];
  endfunction

  task automatic check(input string name, input int vec, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (case %0d): got %0h, expected %0h", name, vec, act, exp);
    end
  endtask

  task automatic write_table(input int pat);
    for (int k = 0; k < 21; k++) begin
      wr_en = 1'b1; wr_addr = 5'(k); wr_data = pat_val(pat, k);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  // Pulse start, optionally re-pulse at cycles e1/e2, and wait for done or error.
  task automatic run_load(input int w, input int e1, input int e2,
                          output int lat, output logic b1, output logic er1);
    which_r = w;
    strb_n = 0;
    done_cnt = 0;
    lat = -1;
    b1 = 1'b0;
    er1 = 1'b1;
    if (w == 1) start0 = 1'b1; else start3 = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      start3 = (w == 0) && (k == e1 || k == e2);
      start0 = (w == 1) && (k == e1 || k == e2);
      if (k == 1) begin b1 = cur_busy; er1 = cur_error; end
      if (k > 1 && (cur_done || cur_error)) begin lat = k; break; end
    end
    start3 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic check_strobes(input int vec, input int pat, input int gap);
    int bad_v, bad_c;
    bad_v = 0;
    bad_c = 0;
    check("strobe_count", vec, strb_n, 21);
    for (int j = 0; j < 21; j++) if (strb_val[j] !== pat_val(pat, 20 - j)) bad_v++;
    for (int j = 1; j < 21; j++) if (strb_cyc[j] - strb_cyc[j-1] != gap + 1) bad_c++;
    check("strobe_values", vec, bad_v, 0);
    check("strobe_spacing", vec, bad_c, 0);
  endtask

  typedef struct {
    int          which;
    int          pat;
    bit          fen;
    int          fidx;
    logic [15:0] fval;
    bit          exp_done;
    int          exp_idx;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    logic b1, er1;
    int bad;

    vecs[0] = '{0, 0, 1'b0, 0,  16'h0000, 1'b1, 0,  117};
    vecs[1] = '{0, 0, 1'b1, 5,  16'hDEAD, 1'b0, 5,  97};
    vecs[2] = '{0, 2, 1'b1, 0,  16'hA5A4, 1'b0, 0,  87};
    vecs[3] = '{0, 0, 1'b1, 15, 16'h0F0E, 1'b0, 15, 117};
    vecs[4] = '{0, 0, 1'b1, 16, 16'h0000, 1'b1, 0,  117};
    vecs[5] = '{1, 1, 1'b0, 0,  16'h0000, 1'b1, 0,  54};
    vecs[6] = '{1, 0, 1'b1, 7,  16'h0000, 1'b0, 7,  38};
    vecs[7] = '{1, 2, 1'b0, 0,  16'h0000, 1'b1, 0,  54};

    // Reset state
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_coef_out", 0, coef3, 0);
    check("rst_coef_shift", 0, shift3, 0);
    check("rst_sel", 0, sel3, 0);
    check("rst_busy", 0, busy3, 0);
    check("rst_done", 0, done3, 0);
    check("rst_error", 0, error3, 0);
    check("rst_err_idx", 0, eidx3, 0);
    check("rst_busy_gap0", 0, busy0, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven load/verify runs
    for (int v = 0; v < 8; v++) begin
      write_table(vecs[v].pat);
      force_en = vecs[v].fen; force_idx = vecs[v].fidx; force_val = vecs[v].fval;
      run_load(vecs[v].which, -1, -1, lat, b1, er1);
      check("busy_after_start", v, b1, 1);
      check("error_cleared", v, er1, 0);
      check("latency", v, lat, vecs[v].exp_lat);
      check("done_flag", v, cur_done, vecs[v].exp_done);
      check("error_flag", v, cur_error, !vecs[v].exp_done);
      if (!vecs[v].exp_done) check("err_idx", v, cur_eidx, vecs[v].exp_idx);
      check("busy_end", v, cur_busy, 0);
      check_strobes(v, vecs[v].pat, (vecs[v].which == 1) ? 0 : 3);
      if (vecs[v].exp_done) begin
        bad = 0;
        for (int k = 0; k < 21; k++) if (model_tap(vecs[v].which, k) !== pat_val(vecs[v].pat, k)) bad++;
        check("fir_taps", v, bad, 0);
      end
      repeat (3) @(posedge clk);
      #1;
      check("done_pulses", v, done_cnt, vecs[v].exp_done ? 1 : 0);
      check("error_sticky", v, cur_error, !vecs[v].exp_done);
      $display("[TB] case %0d: gap_dut=%0d latency=%0d done=%0d error=%0d err_idx=%0d strobes=%0d",
               v, (vecs[v].which == 1) ? 0 : 3, lat, cur_done, cur_error, cur_eidx, strb_n);
      force_en = 1'b0;
    end

    // start pulses while busy are ignored
    write_table(0);
    run_load(0, 10, 50, lat, b1, er1);
    check("busy_ign_latency", 8, lat, 117);
    check_strobes(8, 0, 3);
    repeat (3) @(posedge clk);
    #1;
    check("busy_ign_done_pulses", 8, done_cnt, 1);
    check("busy_ign_idle", 8, busy3, 0);
    $display("[TB] case 8: restart-while-busy latency=%0d strobes=%0d dones=%0d", lat, strb_n, done_cnt);

    // start coinciding with the final compare cycle is ignored
    run_load(0, 116, -1, lat, b1, er1);
    check("ret_latency", 9, lat, 117);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (busy3 !== 1'b0) bad++;
    end
    check("ret_start_ignored", 9, bad, 0);
    check("ret_no_strobes", 9, strb_n, 21);
    $display("[TB] case 9: start-at-return latency=%0d busy_violations=%0d", lat, bad);

    // reset mid-LOAD, then a clean reload
    which_r = 0;
    strb_n = 0;
    start3 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start3 = 1'b0;
    end
    check("midrst_busy_before", 10, busy3, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_coef_out", 10, coef3, 0);
    check("midrst_coef_shift", 10, shift3, 0);
    check("midrst_sel", 10, sel3, 0);
    check("midrst_busy", 10, busy3, 0);
    check("midrst_done", 10, done3, 0);
    check("midrst_error", 10, error3, 0);
    check("midrst_err_idx", 10, eidx3, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_load(0, -1, -1, lat, b1, er1);
    check("midrst_reload_latency", 10, lat, 117);
    check("midrst_reload_done", 10, done3, 1);
    check_strobes(10, 0, 3);
    $display("[TB] case 10: mid-load reset then reload latency=%0d done=%0d", lat, done3);

    // out-of-range writes leave the table untouched
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 16'h1234;
    @(posedge clk); #1;
    wr_addr = 5'd21; wr_data = 16'h4321;
    @(posedge clk); #1;
    wr_en = 1'b0;
    run_load(0, -1, -1, lat, b1, er1);
    check("oob_latency", 11, lat, 117);
    check("oob_done", 11, done3, 1);
    check_strobes(11, 0, 3);
    bad = 0;
    for (int k = 0; k < 21; k++) if (tap3[k] !== pat_val(0, k)) bad++;
    check("oob_taps", 11, bad, 0);
    $display("[TB] case 11: out-of-range write then load latency=%0d done=%0d", lat, done3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
